// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles the execute-side handshake and the write-back bus of the
// writeback_arbiter.
//   master : execute side / register file side (drives flush, exe_vaild,
//            exe_info; observes exe_ready and wb_*)
//   slave  : the arbiter itself
// Parameters:
//   REQ_NUM  number of requesting execution units
//   DW       result data width
//   RNBIT    rename bits; physical register index is 5+RNBIT bits
// ----------------------------------------------------------------------------
interface writeback_arbiter_if #(
  parameter int REQ_NUM = 6,
  parameter int DW      = 64,
  parameter int RNBIT   = 2
);
  localparam int IW = 5 + RNBIT;
  localparam int EW = IW + DW;

  logic                    flush;
  logic [REQ_NUM-1:0]      exe_vaild;
  logic [REQ_NUM-1:0]      exe_ready;
  logic [REQ_NUM*EW-1:0]   exe_info;
  logic                    wb_vaild;
  logic [IW-1:0]           wb_rd;
  logic [DW-1:0]           wb_res;
  logic [REQ_NUM-1:0]      wb_grant;

  modport master (
    output flush, exe_vaild, exe_info,
    input  exe_ready, wb_vaild, wb_rd, wb_res, wb_grant
  );

  modport slave (
    input  flush, exe_vaild, exe_info,
    output exe_ready, wb_vaild, wb_rd, wb_res, wb_grant
  );
endinterface

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Shares the single integer register-file write port among the execution
// units. Each unit result lands in a one-entry holding register; one held
// result per cycle is granted and driven out through a registered
// write-back stage.
//
// Ports:
//   CLK               clock, rising edge
//   RST               asynchronous, active-high reset
//   bus (slave)       flush, exe_vaild/exe_ready/exe_info handshake,
//                     wb_vaild/wb_rd/wb_res/wb_grant write-back outputs
//
// Configuration macro:
//   WB_ARB_FIXPRIO_EN  when defined, the lowest-index held entry always wins
//                      and no round-robin pointer exists. Default (undefined)
//                      is round-robin starting at rr_ptr.
// ----------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int REQ_NUM = 6,
  parameter int DW      = 64,
  parameter int RNBIT   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  writeback_arbiter_if.slave bus
);
  localparam int IW = 5 + RNBIT;
  localparam int EW = IW + DW;
  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [REQ_NUM-1:0] hold_vaild;
  logic [IW-1:0]      hold_rd  [REQ_NUM];
  logic [DW-1:0]      hold_res [REQ_NUM];

  logic [IW-1:0]      in_rd    [REQ_NUM];
  logic [DW-1:0]      in_res   [REQ_NUM];
  logic [REQ_NUM-1:0] in_x0;
  logic [REQ_NUM-1:0] accept;

  logic [REQ_NUM-1:0] grant;
  logic               gnt_any;
  logic [PW-1:0]      gnt_idx;
  int                 cand;

`ifndef WB_ARB_FIXPRIO_EN
  logic [PW-1:0]      rr_ptr;
`endif

  // ---- input slicing and accept ----
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_in
    assign in_rd[i]  = bus.exe_info[i*EW+DW +: IW];
    assign in_res[i] = bus.exe_info[i*EW +: DW];
    // Architectural x0 destinations are consumed but never written.
    assign in_x0[i]  = (in_rd[i][IW-1:RNBIT] == '0);
  end

  // A slot granted this cycle is free for a same-cycle refill.
  assign bus.exe_ready = {REQ_NUM{~bus.flush}} & (~hold_vaild | grant);
  assign accept        = bus.exe_vaild & bus.exe_ready;

  // ---- grant selection ----
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int n = 0; n < REQ_NUM; n++) begin
`ifdef WB_ARB_FIXPRIO_EN
      cand = n;
`else
      cand = int'(rr_ptr) + n;
      if (cand >= REQ_NUM) cand = cand - REQ_NUM;
`endif
      if (!gnt_any && hold_vaild[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
    if (bus.flush) gnt_any = 1'b0;
    grant = gnt_any ? (REQ_NUM'(1) << gnt_idx) : '0;
  end

  // ---- holding stage: control ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_vaild <= '0;
    end else if (bus.flush) begin
      hold_vaild <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (accept[i])     hold_vaild[i] <= ~in_x0[i];
        else if (grant[i]) hold_vaild[i] <= 1'b0;
      end
    end
  end

  // ---- holding stage: data ----
  always_ff @(posedge CLK) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (accept[i] && !in_x0[i]) begin
        hold_rd[i]  <= in_rd[i];
        hold_res[i] <= in_res[i];
      end
    end
  end

`ifndef WB_ARB_FIXPRIO_EN
  // ---- round-robin pointer ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == PW'(REQ_NUM - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end
`endif

  // ---- write-back stage ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.wb_vaild <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_res   <= '0;
      bus.wb_grant <= '0;
    end else if (gnt_any) begin
      bus.wb_vaild <= 1'b1;
      bus.wb_rd    <= hold_rd[gnt_idx];
      bus.wb_res   <= hold_res[gnt_idx];
      bus.wb_grant <= grant;
    end else begin
      bus.wb_vaild <= 1'b0;
      bus.wb_grant <= '0;
    end
  end

endmodule
